// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: stall bus layout, stall patterns, FSM states.
package pipe_ctrl_pkg;

    localparam int STALL_W = 6;

    localparam int STALL_PC  = 0;
    localparam int STALL_IF  = 1;
    localparam int STALL_ID  = 2;
    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;

    localparam logic [STALL_W-1:0] STALL_NONE_P = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_ID_P   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_EX_P   = 6'b001111;

    typedef enum logic [1:0] {
        CTRL_IDLE,
        CTRL_EX_WAIT,
        CTRL_FLUSH
    } ctrl_state_e;

endpackage

// File: rtl/pipe_ctrl_perf_cnt.sv
// 32-bit enable-gated wrapping event counter with synchronous reset.
module perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    output logic [31:0] cnt_o
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) cnt_d = cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stall vector and flush strobe from load-use, multi-cycle EX and flush sources.
// Optional stall performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W        = 6,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_id_i,
    input  logic             exmc_start_i,
    input  logic [CNT_W-1:0] exmc_cycles_i,
    input  logic             flush_req_i,
    output logic [5:0]       stall_o,
    output logic             flush_o,
`ifdef PIPE_CTRL_PERF_EN
    output logic [31:0]      stall_id_cnt_o,
    output logic [31:0]      stall_ex_cnt_o,
`endif
    output logic             busy_o
);

    localparam int FC_W = $clog2(FLUSH_CYCLES + 1);
    localparam logic [FC_W-1:0] FCNT_RELOAD = FC_W'(FLUSH_CYCLES - 1);

    ctrl_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [FC_W-1:0]  fcnt_q, fcnt_d;
    logic [5:0]       stall_d;
    logic             flush_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CTRL_IDLE;
            cnt_q   <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fcnt_q  <= fcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fcnt_d  = fcnt_q;
        stall_d = STALL_NONE_P;
        flush_d = 1'b0;

        unique case (state_q)
            CTRL_IDLE: begin
                if (flush_req_i) begin
                    flush_d = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = CTRL_FLUSH;
                        fcnt_d  = FCNT_RELOAD;
                    end
                end else if (exmc_start_i && exmc_cycles_i >= CNT_W'(2)) begin
                    stall_d = STALL_EX_P;
                    // First stall cycle is this one, so the FSM covers the remaining N-2.
                    if (exmc_cycles_i > CNT_W'(2)) begin
                        state_d = CTRL_EX_WAIT;
                        cnt_d   = exmc_cycles_i - CNT_W'(2);
                    end
                end else if (stallreq_id_i) begin
                    stall_d = STALL_ID_P;
                end
            end

            CTRL_EX_WAIT: begin
                if (flush_req_i) begin
                    flush_d = 1'b1;
                    cnt_d   = '0;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = CTRL_FLUSH;
                        fcnt_d  = FCNT_RELOAD;
                    end else begin
                        state_d = CTRL_IDLE;
                    end
                end else begin
                    stall_d = STALL_EX_P;
                    cnt_d   = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = CTRL_IDLE;
                end
            end

            CTRL_FLUSH: begin
                flush_d = 1'b1;
                if (flush_req_i) begin
                    fcnt_d = FCNT_RELOAD;
                end else begin
                    fcnt_d = fcnt_q - FC_W'(1);
                    if (fcnt_q == FC_W'(1)) state_d = CTRL_IDLE;
                end
            end

            default: state_d = CTRL_IDLE;
        endcase
    end

    assign stall_o = rst ? STALL_NONE_P : stall_d;
    assign flush_o = rst ? 1'b0 : flush_d;
    assign busy_o  = rst ? 1'b0 : (state_q != CTRL_IDLE);

`ifdef PIPE_CTRL_PERF_EN
    perf_cnt u_id_cnt (
        .clk   (clk),
        .rst   (rst),
        .en_i  (stall_o == STALL_ID_P),
        .cnt_o (stall_id_cnt_o)
    );

    perf_cnt u_ex_cnt (
        .clk   (clk),
        .rst   (rst),
        .en_i  (stall_o == STALL_EX_P),
        .cnt_o (stall_ex_cnt_o)
    );
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: per-cycle vector table with an expectation queue, plus corner sequences.
module tb_pipe_ctrl;

    localparam int CNT_W = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             stallreq_id_i;
    logic             exmc_start_i;
    logic [CNT_W-1:0] exmc_cycles_i;
    logic             flush_req_i;
    logic [5:0]       stall_o;
    logic             flush_o;
    logic             busy_o;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0]      stall_id_cnt_o;
    logic [31:0]      stall_ex_cnt_o;
`endif

    always #5 clk = ~clk;

    pipe_ctrl #(.CNT_W(CNT_W), .FLUSH_CYCLES(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .stallreq_id_i (stallreq_id_i),
        .exmc_start_i  (exmc_start_i),
        .exmc_cycles_i (exmc_cycles_i),
        .flush_req_i   (flush_req_i),
        .stall_o       (stall_o),
        .flush_o       (flush_o),
`ifdef PIPE_CTRL_PERF_EN
        .stall_id_cnt_o(stall_id_cnt_o),
        .stall_ex_cnt_o(stall_ex_cnt_o),
`endif
        .busy_o        (busy_o)
    );

    typedef struct {
        logic       rst;
        logic       id;
        logic       start;
        logic [5:0] cyc;
        logic       flush;
        logic [5:0] e_stall;
        logic       e_flush;
        logic       e_busy;
    } vec_t;

    typedef struct {
        int         idx;
        logic [5:0] stall;
        logic       flush;
        logic       busy;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    localparam logic [5:0] SN = 6'b000000;
    localparam logic [5:0] SI = 6'b000111;
    localparam logic [5:0] SE = 6'b001111;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic add(input logic r, input logic id, input logic st, input logic [5:0] cy,
                       input logic fl, input logic [5:0] es, input logic ef, input logic eb);
        vec_t v;
        v.rst = r; v.id = id; v.start = st; v.cyc = cy; v.flush = fl;
        v.e_stall = es; v.e_flush = ef; v.e_busy = eb;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic id, input logic st, input logic [5:0] cy,
                         input logic fl);
        @(posedge clk);
        #1;
        rst = r; stallreq_id_i = id; exmc_start_i = st; exmc_cycles_i = cy; flush_req_i = fl;
    endtask

    initial begin
        exp_t e;
        int   ex_run;
        rst = 1'b1; stallreq_id_i = 1'b0; exmc_start_i = 1'b0; exmc_cycles_i = '0; flush_req_i = 1'b0;

        //   rst id st cyc fl   stall flush busy
        // reset held with live requests, then clean release
        add(1, 1, 0, 0, 1,  SN, 0, 0);
        add(1, 1, 0, 0, 1,  SN, 0, 0);
        add(1, 1, 0, 0, 1,  SN, 0, 0);
        add(0, 0, 0, 0, 0,  SN, 0, 0);
        // load-use for two cycles
        add(0, 1, 0, 0, 0,  SI, 0, 0);
        add(0, 1, 0, 0, 0,  SI, 0, 0);
        add(0, 0, 0, 0, 0,  SN, 0, 0);
        // N=5: four EX stall cycles
        add(0, 0, 1, 5, 0,  SE, 0, 0);
        add(0, 0, 0, 0, 0,  SE, 0, 1);
        add(0, 0, 0, 0, 0,  SE, 0, 1);
        add(0, 0, 0, 0, 0,  SE, 0, 1);
        add(0, 0, 0, 0, 0,  SN, 0, 0);
        // N=2 and N=1
        add(0, 0, 1, 2, 0,  SE, 0, 0);
        add(0, 0, 0, 0, 0,  SN, 0, 0);
        add(0, 0, 1, 1, 0,  SN, 0, 0);
        add(0, 0, 0, 0, 0,  SN, 0, 0);
        // N=3 with load-use; restart during EX_WAIT ignored
        add(0, 1, 1, 3, 0,  SE, 0, 0);
        add(0, 1, 1, 5, 0,  SE, 0, 1);
        add(0, 0, 0, 0, 0,  SN, 0, 0);
        // flush aborts N=6 on its second cycle
        add(0, 0, 1, 6, 0,  SE, 0, 0);
        add(0, 0, 0, 0, 1,  SN, 1, 1);
        add(0, 0, 0, 0, 0,  SN, 1, 1);
        add(0, 0, 0, 0, 0,  SN, 0, 0);
        // flush reload while in FLUSH, inputs ignored there
        add(0, 0, 0, 0, 1,  SN, 1, 0);
        add(0, 1, 1, 9, 1,  SN, 1, 1);
        add(0, 1, 0, 0, 0,  SN, 1, 1);
        add(0, 0, 0, 0, 0,  SN, 0, 0);
        // reset mid-EX_WAIT
        add(0, 0, 1, 10, 0, SE, 0, 0);
        add(0, 0, 0, 0, 0,  SE, 0, 1);
        add(1, 0, 0, 0, 0,  SN, 0, 0);
        add(0, 0, 0, 0, 0,  SN, 0, 0);
        // reset mid-FLUSH
        add(0, 0, 0, 0, 1,  SN, 1, 0);
        add(1, 0, 0, 0, 0,  SN, 0, 0);
        add(0, 0, 0, 0, 0,  SN, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].id, vecs[i].start, vecs[i].cyc, vecs[i].flush);
            e.idx = i; e.stall = vecs[i].e_stall; e.flush = vecs[i].e_flush; e.busy = vecs[i].e_busy;
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front();
            check($sformatf("v%0d stall", e.idx), 32'(stall_o), 32'(e.stall));
            check($sformatf("v%0d flush", e.idx), 32'(flush_o), 32'(e.flush));
            check($sformatf("v%0d busy",  e.idx), 32'(busy_o),  32'(e.busy));
        end

        // maximum N must give N-1 stall cycles without counter wrap
        drive(0, 0, 1, 6'd63, 0);
        ex_run = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (stall_o != SE) break;
            ex_run++;
            drive(0, 0, 0, 0, 0);
        end
        check("maxN stall cycles", 32'(ex_run), 32'd62);
        check("maxN busy after", 32'(busy_o), 32'd0);

`ifdef PIPE_CTRL_PERF_EN
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        drive(0, 0, 1, 5, 0);
        repeat (4) drive(0, 0, 0, 0, 0);
        @(negedge clk);
        check("perf id count", stall_id_cnt_o, 32'd2);
        check("perf ex count", stall_ex_cnt_o, 32'd4);
        drive(1, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check("perf id after rst", stall_id_cnt_o, 32'd0);
        check("perf ex after rst", stall_ex_cnt_o, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline sequencer for the 5-stage core: owns the 6-bit stall vector (PC, IF, ID, EX, MEM, WB) and the flush strobe.
- Arbitrates three sources:
  - load-use stall requests from decode;
  - multi-cycle EX operations (mult/div) that run for a known number of cycles;
  - flush requests from exception/branch logic.
- Sits beside the pipeline registers; every stage register and the PC consume its outputs.

Parameters:
- CNT_W, 6, width of the multi-cycle length input and internal down-counter.
- FLUSH_CYCLES, 2, number of consecutive cycles flush_o stays high per flush request (≥1).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high (`RstEnable`).
- stallreq_id_i  in  1  decode hazard (load-use); level, same-cycle.
- exmc_start_i  in  1  EX begins a multi-cycle op this cycle; single-cycle pulse.
- exmc_cycles_i  in  CNT_W  total EX occupancy N of that op, sampled when exmc_start_i=1.
- flush_req_i  in  1  flush request pulse.
- stall_o  out  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = hold.
- flush_o  out  1  clear IF/ID/EX pipeline registers.
- busy_o  out  1  FSM not in IDLE.

Behaviour:
- Reset:
  - rst high at a clock edge sets state IDLE and cnt=0.
  - While rst is high, stall_o=6'b000000, flush_o=0 and busy_o=0, forced combinationally.
- Outputs are combinational from {state, cnt, inputs}, so stalls take effect in the request cycle.
- Patterns:
  - STALL_NONE=000000
  - STALL_ID=000111
  - STALL_EX=001111
- States: IDLE, EX_WAIT, FLUSH.
- IDLE:
  - flush_req_i=1: flush_o=1, stall_o=NONE. If FLUSH_CYCLES>1, go to FLUSH with fcnt=FLUSH_CYCLES-1.
  - else exmc_start_i=1 with N≥2: stall_o=EX.
    - N=2: stay IDLE.
    - N>2: go to EX_WAIT with cnt=N-2.
  - else exmc_start_i=1 with N∈{0,1}: no stall; treated as a single-cycle op.
  - else stallreq_id_i=1: stall_o=ID.
  - If both stallreq_id_i and a valid exmc start occur, EX pattern wins (it is a superset).
- EX_WAIT:
  - stall_o=EX; cnt decrements each cycle; when cnt==1 the next state is IDLE.
  - Total EX stall cycles for an op = N-1.
  - stallreq_id_i and exmc_start_i are ignored.
- FLUSH:
  - flush_o=1, stall_o=NONE; fcnt decrements; at fcnt==1 the next state is IDLE.
  - stallreq_id_i and exmc_start_i are ignored.
  - A new flush_req_i reloads fcnt=FLUSH_CYCLES-1.
- Priority in every state: flush_req_i over everything.
  - A flush in EX_WAIT aborts the op: cnt is cleared, flush_o=1 in the same cycle, stall drops to NONE in that cycle.
- busy_o = (state != IDLE).
- Reset mid-EX_WAIT or mid-FLUSH: abandon immediately; no residual stall or flush after rst deasserts.
- N values at max (2^CNT_W-1) must not wrap the counter.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- Defined:
  - Adds outputs stall_id_cnt_o[31:0] and stall_ex_cnt_o[31:0].
  - Each counter increments on every non-reset cycle where stall_o equals STALL_ID or STALL_EX respectively.
  - Both wrap at 2^32 and reset to 0.
- Undefined: ports and counters are absent; the remaining behaviour is identical.

Decomposition:
- defs.v gains:
  - `StallBus` 5:0;
  - stall bit indices `StallPC`..`StallWB`;
  - `StallNone`, `StallID`, `StallEX` patterns;
  - FSM state encodings `CtrlIdle`, `CtrlExWait`, `CtrlFlush`.
- One natural sub-module, perf_cnt: 32-bit enable-gated wrapping counter with sync reset, instantiated twice under PIPE_CTRL_PERF_EN.
- FSM and down-counter stay in pipe_ctrl.

Test Plan:
- Reset: rst=1 for 3 cycles while stallreq_id_i=1 and flush_req_i=1 -> stall_o=000000, flush_o=0, busy_o=0 every cycle. After release: IDLE, no stale flush.
- Load-use: stallreq_id_i=1 for 2 cycles in IDLE -> stall_o=000111 exactly those 2 cycles, busy_o=0 throughout.
- Multi-cycle op:
  - exmc_start_i pulse with exmc_cycles_i=5 -> stall_o=001111 for 4 consecutive cycles starting in the pulse cycle, busy_o=1 for cycles 2–4, then 000000.
  - Repeat with N=2 (1 stall cycle) and N=1 (0 stall cycles).
- Combined: exmc_start_i (N=3) and stallreq_id_i together -> 001111 for 2 cycles. A second exmc_start_i during EX_WAIT is ignored, with no extra cycles.
- Flush abort: flush_req_i on the 2nd cycle of an N=6 op -> that cycle stall_o=000000, flush_o=1. flush_o=1 one more cycle (FLUSH_CYCLES=2), then IDLE; no remaining EX stall.
- Perf (PIPE_CTRL_PERF_EN): run the load-use then N=5 scenarios -> stall_id_cnt_o=2, stall_ex_cnt_o=4. Then rst -> both read 0.
